// File: rtl/fp_agg_sched_if.sv
// fp_agg_sched_if -- bundle of every non-clock signal of fp_agg_sched.
//
// Signal groups (direction as seen from the scheduler, i.e. the slave modport):
//   s_axis_N_tdata/tvalid   in   operand lanes N = 0..3
//   s_axis_N_tready         out  lane N is empty
//   add_N_tdata/tvalid      out  operands and issue strobe to the adder tree
//   fifo_empty, fifo_dout   in   result FIFO status and read data (latency 1)
//   fifo_rd_en              out  result FIFO pop
//   m_axis_tdata/tvalid     out  result stream
//   m_axis_tready           in   result stream back-pressure
//   outstanding             out  sets issued but not yet read back from the FIFO
//   timeout_pulse           out  one-cycle flag when a partial set is zero-padded
//
// Modports: slave is the scheduler itself, master is the surrounding logic.
// The parameters must match the ones given to fp_agg_sched.
interface fp_agg_sched_if #(
  parameter int FP_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH    = 16
);
  localparam int OUT_W = $clog2(FIFO_DEPTH + 1);

  logic [FP_DATA_WIDTH-1:0] s_axis_0_tdata;
  logic [FP_DATA_WIDTH-1:0] s_axis_1_tdata;
  logic [FP_DATA_WIDTH-1:0] s_axis_2_tdata;
  logic [FP_DATA_WIDTH-1:0] s_axis_3_tdata;
  logic                     s_axis_0_tvalid;
  logic                     s_axis_1_tvalid;
  logic                     s_axis_2_tvalid;
  logic                     s_axis_3_tvalid;
  logic                     s_axis_0_tready;
  logic                     s_axis_1_tready;
  logic                     s_axis_2_tready;
  logic                     s_axis_3_tready;

  logic [FP_DATA_WIDTH-1:0] add_0_tdata;
  logic [FP_DATA_WIDTH-1:0] add_1_tdata;
  logic [FP_DATA_WIDTH-1:0] add_2_tdata;
  logic [FP_DATA_WIDTH-1:0] add_3_tdata;
  logic                     add_0_tvalid;
  logic                     add_1_tvalid;
  logic                     add_2_tvalid;
  logic                     add_3_tvalid;

  logic                     fifo_empty;
  logic [FP_DATA_WIDTH-1:0] fifo_dout;
  logic                     fifo_rd_en;

  logic [FP_DATA_WIDTH-1:0] m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;

  logic [OUT_W-1:0]         outstanding;
  logic                     timeout_pulse;

  modport slave (
    input  s_axis_0_tdata, s_axis_1_tdata, s_axis_2_tdata, s_axis_3_tdata,
    input  s_axis_0_tvalid, s_axis_1_tvalid, s_axis_2_tvalid, s_axis_3_tvalid,
    output s_axis_0_tready, s_axis_1_tready, s_axis_2_tready, s_axis_3_tready,
    output add_0_tdata, add_1_tdata, add_2_tdata, add_3_tdata,
    output add_0_tvalid, add_1_tvalid, add_2_tvalid, add_3_tvalid,
    input  fifo_empty, fifo_dout,
    output fifo_rd_en,
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready,
    output outstanding, timeout_pulse
  );

  modport master (
    output s_axis_0_tdata, s_axis_1_tdata, s_axis_2_tdata, s_axis_3_tdata,
    output s_axis_0_tvalid, s_axis_1_tvalid, s_axis_2_tvalid, s_axis_3_tvalid,
    input  s_axis_0_tready, s_axis_1_tready, s_axis_2_tready, s_axis_3_tready,
    input  add_0_tdata, add_1_tdata, add_2_tdata, add_3_tdata,
    input  add_0_tvalid, add_1_tvalid, add_2_tvalid, add_3_tvalid,
    output fifo_empty, fifo_dout,
    input  fifo_rd_en,
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready,
    input  outstanding, timeout_pulse
  );
endinterface

// File: rtl/fp_agg_sched.sv
// fp_agg_sched -- gathers one operand per lane from four input streams,
// issues the complete set of four to an adder tree in a single cycle, tracks
// how many sets have results pending in the downstream result FIFO (holding
// new issues while that FIFO could overflow) and drains the FIFO onto an
// output stream. Operands pass through unmodified.
//
// Ports:
//   aclk     in  clock
//   aresetn  in  asynchronous active-low reset
//   bus      fp_agg_sched_if.slave -- lane inputs, adder-tree issue outputs,
//            result FIFO read side, result stream, outstanding count and
//            timeout pulse (see the interface file for the signal list)
//
// Build option: define FP_SCHED_TIMEOUT_EN to zero-pad a partial set after it
// has waited TIMEOUT_CYCLES cycles. Without it partial sets wait forever and
// timeout_pulse is tied low.
module fp_agg_sched #(
  parameter int FP_DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          aclk,
  input  logic          aresetn,
  fp_agg_sched_if.slave bus
);

  localparam int OUT_W = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fp_agg_sched: FIFO_DEPTH and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {COLLECT, HOLD, ISSUE} state_t;

  state_t                   state;
  logic [FP_DATA_WIDTH-1:0] lane_data [4];
  logic [FP_DATA_WIDTH-1:0] lane_in   [4];
  logic [3:0]               lane_full;
  logic [3:0]               lane_valid;
  logic [3:0]               capture;
  logic                     all_full;
  logic                     room;
  logic                     fire;

  logic                     issue_valid;
  logic [FP_DATA_WIDTH-1:0] issue_data [4];
  logic [OUT_W-1:0]         outstanding;
  logic                     rd_pending;
  logic                     rd_en;
  logic                     m_valid;
  logic [FP_DATA_WIDTH-1:0] m_data;

  assign lane_in[0] = bus.s_axis_0_tdata;
  assign lane_in[1] = bus.s_axis_1_tdata;
  assign lane_in[2] = bus.s_axis_2_tdata;
  assign lane_in[3] = bus.s_axis_3_tdata;
  assign lane_valid = {bus.s_axis_3_tvalid, bus.s_axis_2_tvalid,
                       bus.s_axis_1_tvalid, bus.s_axis_0_tvalid};

  assign bus.s_axis_0_tready = !lane_full[0];
  assign bus.s_axis_1_tready = !lane_full[1];
  assign bus.s_axis_2_tready = !lane_full[2];
  assign bus.s_axis_3_tready = !lane_full[3];

  assign capture  = lane_valid & ~lane_full;
  assign all_full = &lane_full;
  assign room     = outstanding < OUT_W'(FIFO_DEPTH);

`ifdef FP_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_count;
  logic            to_pulse;
  logic            partial;

  // Only a set that is neither empty nor complete ages; ISSUE always has all
  // four lanes full, so the counter is cleared there as well.
  assign partial = (lane_full != 4'b0000) && !all_full;
  assign fire    = (state == COLLECT) && partial &&
                   (to_count == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      to_count <= '0;
      to_pulse <= 1'b0;
    end else begin
      to_pulse <= fire;
      if (state == COLLECT && partial && !fire)
        to_count <= to_count + 1'b1;
      else
        to_count <= '0;
    end
  end

  assign bus.timeout_pulse = to_pulse;
`else
  assign fire              = 1'b0;
  assign bus.timeout_pulse = 1'b0;
`endif

  // Lane storage and the issue FSM. The adder operands are loaded on the
  // transition into ISSUE so that add_N_tvalid is high exactly while the FSM
  // sits in ISSUE; lanes stay full and stable during that cycle and are
  // released at its closing edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= COLLECT;
      lane_full   <= 4'b0000;
      issue_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        lane_data[i]  <= '0;
        issue_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (state == ISSUE) begin
          lane_full[i] <= 1'b0;
        end else if (capture[i]) begin
          lane_data[i] <= lane_in[i];
          lane_full[i] <= 1'b1;
        end else if (fire && !lane_full[i]) begin
          lane_data[i] <= '0;
          lane_full[i] <= 1'b1;
        end
      end

      case (state)
        COLLECT: begin
          if (all_full) begin
            if (room) begin
              state       <= ISSUE;
              issue_valid <= 1'b1;
              for (int i = 0; i < 4; i++) issue_data[i] <= lane_data[i];
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (room) begin
            state       <= ISSUE;
            issue_valid <= 1'b1;
            for (int i = 0; i < 4; i++) issue_data[i] <= lane_data[i];
          end
        end
        ISSUE: begin
          state       <= COLLECT;
          issue_valid <= 1'b0;
        end
        default: begin
          state       <= COLLECT;
          issue_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.add_0_tvalid = issue_valid;
  assign bus.add_1_tvalid = issue_valid;
  assign bus.add_2_tvalid = issue_valid;
  assign bus.add_3_tvalid = issue_valid;
  assign bus.add_0_tdata  = issue_data[0];
  assign bus.add_1_tdata  = issue_data[1];
  assign bus.add_2_tdata  = issue_data[2];
  assign bus.add_3_tdata  = issue_data[3];

  // A FIFO read is launched only when nothing is in flight toward or sitting
  // on the output register, so one output slot is all the buffering needed.
  assign rd_en          = aresetn && !bus.fifo_empty && !rd_pending && !m_valid;
  assign bus.fifo_rd_en = rd_en;

  // Sets issued minus sets read back; saturating guards keep it in range even
  // if the FIFO owner reads after a reset wiped the count.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outstanding <= '0;
    end else begin
      case ({state == ISSUE && room, rd_en && outstanding != '0})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign bus.outstanding = outstanding;

  // FIFO data appears one cycle after the read strobe and is parked in the
  // output register until the consumer accepts it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_pending <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
    end else begin
      if (rd_pending) begin
        m_data     <= bus.fifo_dout;
        m_valid    <= 1'b1;
        rd_pending <= 1'b0;
      end else if (rd_en) begin
        rd_pending <= 1'b1;
      end else if (m_valid && bus.m_axis_tready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign bus.m_axis_tvalid = m_valid;
  assign bus.m_axis_tdata  = m_data;

endmodule

// File: tb/tb_fp_agg_sched.sv
// tb_fp_agg_sched -- directed self-checking bench for fp_agg_sched.
// Inputs change 1 time unit after the rising edge and outputs are sampled
// there as well, away from the active edge.
module tb_fp_agg_sched;

  logic aclk;
  logic aresetn;
  int   checks;
  int   failures;

  fp_agg_sched_if #(.FP_DATA_WIDTH(32), .FIFO_DEPTH(16)) bus ();

  fp_agg_sched #(
    .FP_DATA_WIDTH (32),
    .FIFO_DEPTH    (16),
    .TIMEOUT_CYCLES(256)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic [3:0] rdy;
  logic [3:0] add_v;
  assign rdy   = {bus.s_axis_3_tready, bus.s_axis_2_tready,
                  bus.s_axis_1_tready, bus.s_axis_0_tready};
  assign add_v = {bus.add_3_tvalid, bus.add_2_tvalid,
                  bus.add_1_tvalid, bus.add_0_tvalid};

  task automatic do_reset;
    aresetn             = 1'b0;
    bus.s_axis_0_tvalid = 1'b0;
    bus.s_axis_1_tvalid = 1'b0;
    bus.s_axis_2_tvalid = 1'b0;
    bus.s_axis_3_tvalid = 1'b0;
    bus.s_axis_0_tdata  = '0;
    bus.s_axis_1_tdata  = '0;
    bus.s_axis_2_tdata  = '0;
    bus.s_axis_3_tdata  = '0;
    bus.fifo_empty      = 1'b1;
    bus.fifo_dout       = '0;
    bus.m_axis_tready   = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  // Presents one word on every lane for a single cycle.
  task automatic drive_set(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
    bus.s_axis_0_tdata  = d0;
    bus.s_axis_1_tdata  = d1;
    bus.s_axis_2_tdata  = d2;
    bus.s_axis_3_tdata  = d3;
    bus.s_axis_0_tvalid = 1'b1;
    bus.s_axis_1_tvalid = 1'b1;
    bus.s_axis_2_tvalid = 1'b1;
    bus.s_axis_3_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    bus.s_axis_0_tvalid = 1'b0;
    bus.s_axis_1_tvalid = 1'b0;
    bus.s_axis_2_tvalid = 1'b0;
    bus.s_axis_3_tvalid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (rdy !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL reset_tready: got %b expected 1111", rdy);
    end
    checks++;
    if (add_v !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_add_tvalid: got %b expected 0000", add_v);
    end
    checks++;
    if (bus.outstanding !== 5'd0 || bus.m_axis_tvalid !== 1'b0 ||
        bus.fifo_rd_en !== 1'b0 || bus.timeout_pulse !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: outstanding=%0d m_tvalid=%b rd_en=%b timeout=%b expected 0 0 0 0",
               bus.outstanding, bus.m_axis_tvalid, bus.fifo_rd_en, bus.timeout_pulse);
    end
    checks++;
    if (bus.m_axis_tdata !== 32'h0 || bus.add_0_tdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: m_tdata=%h add_0=%h expected 0 0",
               bus.m_axis_tdata, bus.add_0_tdata);
    end
  endtask

  task automatic test_single_issue;
    drive_set(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    checks++;
    if (rdy !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL single_lanes_full: tready=%b expected 0000", rdy);
    end
    @(posedge aclk);
    #1;
    checks++;
    if (add_v !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL single_issue_valid: got %b expected 1111", add_v);
    end
    checks++;
    if (bus.add_0_tdata !== 32'h3F800000 || bus.add_1_tdata !== 32'h40000000 ||
        bus.add_2_tdata !== 32'h40400000 || bus.add_3_tdata !== 32'h40800000) begin
      failures++;
      $display("[TB] FAIL single_issue_data: got %h %h %h %h expected 3f800000 40000000 40400000 40800000",
               bus.add_0_tdata, bus.add_1_tdata, bus.add_2_tdata, bus.add_3_tdata);
    end
    @(posedge aclk);
    #1;
    checks++;
    if (add_v !== 4'b0000 || bus.outstanding !== 5'd1 || rdy !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL single_after_issue: tvalid=%b outstanding=%0d tready=%b expected 0000 1 1111",
               add_v, bus.outstanding, rdy);
    end
    checks++;
    if (bus.add_3_tdata !== 32'h40800000) begin
      failures++;
      $display("[TB] FAIL single_data_hold: got %h expected 40800000", bus.add_3_tdata);
    end
  endtask

  // Fills the FIFO accounting to 16, then shows the 17th set being held and
  // released by exactly one FIFO read.
  task automatic test_hold_and_release;
    logic [31:0] base;
    int          bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      base = 32'h41000000 + 32'(i * 4);
      drive_set(base, base + 1, base + 2, base + 3);
      @(posedge aclk);
      #1;
      if (add_v !== 4'b1111 || bus.add_2_tdata !== base + 2) bad++;
      @(posedge aclk);
      #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL fill_issues: %0d bad issue cycles, expected 0", bad);
    end
    checks++;
    if (bus.outstanding !== 5'd16) begin
      failures++;
      $display("[TB] FAIL fill_outstanding: got %0d expected 16", bus.outstanding);
    end
    drive_set(32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003);
    bad = 0;
    repeat (5) begin
      @(posedge aclk);
      #1;
      if (add_v !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0 || rdy !== 4'b0000 || bus.outstanding !== 5'd16) begin
      failures++;
      $display("[TB] FAIL hold_state: bad_issue=%0d tready=%b outstanding=%0d expected 0 0000 16",
               bad, rdy, bus.outstanding);
    end
    bus.fifo_dout  = 32'h55AA0001;
    bus.fifo_empty = 1'b0;
    #1;
    checks++;
    if (bus.fifo_rd_en !== 1'b1) begin
      failures++;
      $display("[TB] FAIL release_rd_en: got %b expected 1", bus.fifo_rd_en);
    end
    @(posedge aclk);
    #1;
    bus.fifo_empty = 1'b1;
    checks++;
    if (bus.outstanding !== 5'd15 || add_v !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL release_dec: outstanding=%0d tvalid=%b expected 15 0000",
               bus.outstanding, add_v);
    end
    @(posedge aclk);
    #1;
    checks++;
    if (add_v !== 4'b1111 || bus.add_0_tdata !== 32'hA0000000 ||
        bus.add_3_tdata !== 32'hA0000003) begin
      failures++;
      $display("[TB] FAIL release_issue: tvalid=%b add_0=%h add_3=%h expected 1111 a0000000 a0000003",
               add_v, bus.add_0_tdata, bus.add_3_tdata);
    end
    @(posedge aclk);
    #1;
    checks++;
    if (bus.outstanding !== 5'd16 || bus.m_axis_tvalid !== 1'b1 ||
        bus.m_axis_tdata !== 32'h55AA0001) begin
      failures++;
      $display("[TB] FAIL release_after: outstanding=%0d m_tvalid=%b m_tdata=%h expected 16 1 55aa0001",
               bus.outstanding, bus.m_axis_tvalid, bus.m_axis_tdata);
    end
  endtask

  // Continues from the full state: a new set parks in HOLD, then reset hits.
  task automatic test_reset_in_hold;
    drive_set(32'hB0000000, 32'hB0000001, 32'hB0000002, 32'hB0000003);
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if (rdy !== 4'b0000 || add_v !== 4'b0000 || bus.outstanding !== 5'd16) begin
      failures++;
      $display("[TB] FAIL hold_before_reset: tready=%b tvalid=%b outstanding=%0d expected 0000 0000 16",
               rdy, add_v, bus.outstanding);
    end
    bus.fifo_empty = 1'b0;
    aresetn        = 1'b0;
    #1;
    checks++;
    if (add_v !== 4'b0000 || bus.add_0_tdata !== 32'h0 || bus.add_3_tdata !== 32'h0 ||
        bus.fifo_rd_en !== 1'b0 || bus.m_axis_tvalid !== 1'b0 ||
        bus.m_axis_tdata !== 32'h0 || bus.outstanding !== 5'd0 ||
        bus.timeout_pulse !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset: tvalid=%b add_0=%h add_3=%h rd_en=%b m_tvalid=%b m_tdata=%h outstanding=%0d timeout=%b expected all zero",
               add_v, bus.add_0_tdata, bus.add_3_tdata, bus.fifo_rd_en,
               bus.m_axis_tvalid, bus.m_axis_tdata, bus.outstanding, bus.timeout_pulse);
    end
    bus.fifo_empty = 1'b1;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    #1;
    checks++;
    if (rdy !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL release_tready: got %b expected 1111", rdy);
    end
    @(posedge aclk);
    #1;
    checks++;
    if (add_v !== 4'b0000 || rdy !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL held_set_discarded: tvalid=%b tready=%b expected 0000 1111", add_v, rdy);
    end
  endtask

  task automatic test_output_read;
    int rd_count;
    int unstable;
    do_reset();
    bus.fifo_dout     = 32'h41200000;
    bus.fifo_empty    = 1'b0;
    bus.m_axis_tready = 1'b0;
    #1;
    rd_count = 0;
    unstable = 0;
    for (int c = 0; c < 7; c++) begin
      if (bus.fifo_rd_en === 1'b1) rd_count++;
      if (c >= 2 && (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 32'h41200000))
        unstable++;
      @(posedge aclk);
      #1;
    end
    checks++;
    if (rd_count != 1) begin
      failures++;
      $display("[TB] FAIL read_single_pulse: got %0d pulses expected 1", rd_count);
    end
    checks++;
    if (unstable != 0 || bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 32'h41200000) begin
      failures++;
      $display("[TB] FAIL read_hold_output: unstable=%0d m_tvalid=%b m_tdata=%h expected 0 1 41200000",
               unstable, bus.m_axis_tvalid, bus.m_axis_tdata);
    end
    checks++;
    if (bus.outstanding !== 5'd0) begin
      failures++;
      $display("[TB] FAIL read_no_underflow: got %0d expected 0", bus.outstanding);
    end
    bus.fifo_empty    = 1'b1;
    bus.m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;
    bus.m_axis_tready = 1'b0;
    checks++;
    if (bus.m_axis_tvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL read_handshake_clear: m_tvalid=%b expected 0", bus.m_axis_tvalid);
    end
  endtask

  task automatic test_partial_set;
    do_reset();
    bus.s_axis_0_tdata  = 32'h3F800000;
    bus.s_axis_1_tdata  = 32'h40000000;
    bus.s_axis_0_tvalid = 1'b1;
    bus.s_axis_1_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    bus.s_axis_0_tvalid = 1'b0;
    bus.s_axis_1_tvalid = 1'b0;
    checks++;
    if (rdy !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL partial_tready: got %b expected 1100", rdy);
    end
`ifdef FP_SCHED_TIMEOUT_EN
    begin
      int got;
      got = 0;
      for (int k = 1; k <= 300; k++) begin
        @(posedge aclk);
        #1;
        if (bus.timeout_pulse === 1'b1) begin
          got = k;
          break;
        end
      end
      checks++;
      if (got != 256) begin
        failures++;
        $display("[TB] FAIL timeout_latency: pulse after %0d cycles expected 256", got);
      end
      @(posedge aclk);
      #1;
      checks++;
      if (bus.timeout_pulse !== 1'b0 || add_v !== 4'b1111 ||
          bus.add_2_tdata !== 32'h0 || bus.add_3_tdata !== 32'h0 ||
          bus.add_0_tdata !== 32'h3F800000 || bus.add_1_tdata !== 32'h40000000) begin
        failures++;
        $display("[TB] FAIL timeout_issue: timeout=%b tvalid=%b data=%h %h %h %h expected 0 1111 3f800000 40000000 0 0",
                 bus.timeout_pulse, add_v, bus.add_0_tdata, bus.add_1_tdata,
                 bus.add_2_tdata, bus.add_3_tdata);
      end
    end
`else
    begin
      int seen;
      seen = 0;
      repeat (1000) begin
        @(posedge aclk);
        #1;
        if (add_v !== 4'b0000 || bus.timeout_pulse !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0 || rdy !== 4'b1100) begin
        failures++;
        $display("[TB] FAIL partial_waits: issue_or_timeout_cycles=%0d tready=%b expected 0 1100",
                 seen, rdy);
      end
    end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_issue();
    test_hold_and_release();
    test_reset_in_hold();
    test_output_read();
    test_partial_set();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_agg_sched.md
FP_AGG_SCHED -- requirements
Module: fp_agg_sched

Interface
REQ-001 SHALL have parameter FP_DATA_WIDTH, default 32, meaning operand/result width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning result FIFO capacity in words.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning partial-set wait limit (used only under FP_SCHED_TIMEOUT_EN).
REQ-004 SHALL have one clock and an asynchronous active-low reset: aclk  in  1  clock; aresetn  in  1  async active-low reset.
REQ-005 SHALL have, for N=0..3: s_axis_N_tdata  in  FP_DATA_WIDTH  lane operand; s_axis_N_tvalid  in  1; s_axis_N_tready  out  1.
REQ-006 SHALL have, for N=0..3: add_N_tdata  out  FP_DATA_WIDTH  adder-tree operand; add_N_tvalid  out  1  issue strobe.
REQ-007 SHALL have fifo_empty  in  1; fifo_dout  in  FP_DATA_WIDTH; fifo_rd_en  out  1  (result FIFO, read latency 1).
REQ-008 SHALL have m_axis_tdata  out  FP_DATA_WIDTH; m_axis_tvalid  out  1; m_axis_tready  in  1.
REQ-009 SHALL have outstanding  out  clog2(FIFO_DEPTH+1)  issued sets not yet read from FIFO; timeout_pulse  out  1.

Function
REQ-010 Lane N SHALL hold one word; s_axis_N_tready = lane N empty; word captured when tvalid&&tready.
REQ-011 FSM states COLLECT, HOLD, ISSUE; reset state COLLECT.
REQ-012 COLLECT: all four lanes full and outstanding<FIFO_DEPTH -> ISSUE; all full and outstanding==FIFO_DEPTH -> HOLD; else stay.
REQ-013 HOLD -> ISSUE when outstanding<FIFO_DEPTH.
REQ-014 ISSUE (exactly one cycle): add_0..3_tvalid=1 simultaneously, add_N_tdata=lane N; all lanes cleared at clock edge; -> COLLECT.
REQ-015 add_N_tvalid SHALL be 0 outside ISSUE; add_N_tdata SHALL hold last lane value.
REQ-016 outstanding: +1 on ISSUE, -1 on fifo_rd_en, unchanged if both same cycle; SHALL never exceed FIFO_DEPTH nor underflow.
REQ-017 fifo_rd_en = !fifo_empty && !rd_pending && !m_axis_tvalid; rd_pending set the cycle after fifo_rd_en.
REQ-018 When rd_pending: m_axis_tdata<=fifo_dout, m_axis_tvalid<=1, rd_pending<=0.
REQ-019 m_axis_tvalid SHALL stay 1 and tdata stable until m_axis_tready; cleared on handshake.
REQ-020 Lane data SHALL pass unmodified (no arithmetic); issue order = FIFO order = output order.

Reset
REQ-021 aresetn low SHALL immediately: FSM=COLLECT, lanes empty (tready=1 after release), add_N_tvalid=0, add_N_tdata=0, fifo_rd_en=0, rd_pending=0, m_axis_tvalid=0, m_axis_tdata=0, outstanding=0, timeout_pulse=0, timeout counter=0.
REQ-022 Reset mid-ISSUE/HOLD SHALL discard held lane data; results in flight are not tracked after reset (FIFO reset by owner).

Configuration
REQ-023 Macro FP_SCHED_TIMEOUT_EN defined: counter runs in COLLECT while 1-3 lanes full, clears when 0 or 4 full or on ISSUE; at count TIMEOUT_CYCLES-1 empty lanes load +0.0 (all zeros), are marked full, timeout_pulse=1 for one cycle, normal REQ-012 flow follows.
REQ-024 Macro undefined: no counter logic, partial sets wait indefinitely, timeout_pulse tied 0.

Verification
REQ-025 Lanes 0..3 send 1.0,2.0,3.0,4.0 (0x3F800000,0x40000000,0x40400000,0x40800000) -> one ISSUE cycle, add_N_tdata matches, outstanding=1.
REQ-026 Issue FIFO_DEPTH=16 sets with m_axis_tready=0 and FIFO never read -> 17th set enters HOLD, add_N_tvalid stays 0, all tready=0.
REQ-027 From REQ-026, pulse one FIFO read -> outstanding 16->15, HOLD->ISSUE next cycle, outstanding back to 16.
REQ-028 fifo_empty=0, fifo_dout=0x41200000, m_axis_tready=0 for 5 cycles -> m_axis_tvalid=1, tdata 0x41200000 stable, single fifo_rd_en pulse.
REQ-029 With FP_SCHED_TIMEOUT_EN, only lanes 0,1 written -> after 256 cycles timeout_pulse=1, add_2/3_tdata=0x00000000 on ISSUE; without macro -> no ISSUE after 1000 cycles.
REQ-030 Assert aresetn=0 during HOLD -> all outputs to REQ-021 values same cycle; after release, all s_axis_N_tready=1.
